mul_arbiter: RTL and testbench
==============================

Name: mul_arbiter

Overview:
- Controller that shares the single sequential 8x8 shift-and-add multiplier between two requesters: port 0 is the CPU MUL instruction path, port 1 is the auxiliary/DMA path.
- Arbitrates round-robin and latches operands. Issues a one-cycle start pulse, waits for the multiplier's done pulse, and captures the 16-bit product.
- Returns the product on the winning port's response channel with valid/ready backpressure.
- Includes a watchdog that aborts a hung operation with an error flag.

Parameters:
- TIMEOUT_CYCLES, default 16: maximum number of WAIT-state cycles without mul_done before the operation is aborted. Legal range is 10 to 255.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  2  per-port request valid; bit i belongs to port i
req_ready  out  2  per-port request accept; at most one bit high
req_a  in  16  operand A, port0=[7:0], port1=[15:8]
req_b  in  16  operand B, port0=[7:0], port1=[15:8]
rsp_valid  out  2  per-port response valid; at most one bit high
rsp_ready  in  2  per-port response accept
rsp_data  out  16  product, shared by both ports; meaningful only while the corresponding rsp_valid bit is high
rsp_err  out  1  high with rsp_valid when the response is a timeout abort
mul_start  out  1  one-cycle start pulse to the multiplier
mul_a  out  8  multiplicand to the multiplier, held stable from ISSUE through WAIT
mul_b  out  8  multiplier operand, held stable from ISSUE through WAIT
mul_busy  in  1  multiplier busy
mul_done  in  1  multiplier done pulse
mul_p_low  in  8  product bits [7:0]
mul_p_high  in  8  product bits [15:8]
arb_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n low, async) forces:
  - state = IDLE, last_grant = 1 (so port 0 wins first);
  - timeout counter = 0, rsp_data = 0, rsp_err = 0;
  - all of req_ready, rsp_valid, mul_start, arb_busy, mul_a, mul_b = 0.
- Reset mid-operation discards the operation; no response is ever produced for it.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - grant = the port with req_valid high. If both are high, grant the port not equal to last_grant.
  - req_ready[grant] is combinationally high in IDLE only.
  - On handshake (req_valid & req_ready): latch that port's operands into mul_a/mul_b, set owner = grant, last_grant = grant, go to ISSUE.
  - No request: remain in IDLE.
- ISSUE:
  - mul_start = 1 only when mul_busy = 0, then go to WAIT next cycle.
  - If mul_busy = 1, hold in ISSUE with mul_start = 0.
  - Exactly one start pulse per accepted request.
- WAIT:
  - Timeout counter increments each cycle.
  - mul_done = 1: capture rsp_data = {mul_p_high, mul_p_low}, rsp_err = 0, go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: rsp_data = 0, rsp_err = 1, go to RESP.
  - If mul_done and timeout coincide, done wins.
  - Counter clears on leaving WAIT.
- mul_done seen in IDLE, ISSUE or RESP is ignored.
- RESP:
  - rsp_valid[owner] = 1; rsp_data and rsp_err are held stable.
  - On rsp_ready[owner] = 1, go to IDLE. rsp_ready of the non-owner port is ignored.
  - New requests are not accepted in the same cycle as the response handshake.
- Latency with the standard 8-iteration multiplier:
  - acceptance edge at end of cycle 0;
  - mul_start in cycle 1;
  - mul_done in cycle 10;
  - rsp_valid first high in cycle 11.
- Throughput is one operation per 12 cycles when rsp_ready is tied high.
- Round-robin is strictly alternating under continuous contention. No port waits more than one operation.
- Widths: the product is 16-bit unsigned, passed through unmodified. No sign handling.

Test Plan:
- Port0 only, a=13, b=11, rsp_ready=1 -> one mul_start pulse in cycle 1; rsp_valid[0] in cycle 11 with rsp_data=0x008F, rsp_err=0; port1 rsp_valid stays 0.
- Both ports request from reset: port0 a=255,b=255; port1 a=16,b=16 -> port0 served first with 0xFE01, then port1 with 0x0100. Holding both valid for four operations gives grants 0,1,0,1.
- Backpressure: port1 a=7,b=6, rsp_ready[1]=0 for 5 cycles after rsp_valid -> rsp_valid[1] and rsp_data=0x002A stable for all 5 cycles; req_ready stays 0 throughout; IDLE only after the ready handshake.
- Hung multiplier: mul_done forced to 0, TIMEOUT_CYCLES=16 -> after 16 WAIT cycles rsp_valid[0]=1, rsp_err=1, rsp_data=0x0000; arbiter then accepts the next request normally.
- ISSUE with mul_busy held high for 3 cycles -> mul_start stays 0 during those cycles, then pulses exactly once; result is still correct (9*9=0x0051).
- reset_n asserted low in WAIT -> all outputs 0 immediately, no later rsp_valid. After release, request 2*3 -> 0x0006 with port0 granted first.

Source files
------------

// File: rtl/mul_arbiter.sv
// -----------------------------------------------------------------------------
// mul_arbiter
//
// Shares one sequential 8x8 shift-and-add multiplier between two requesters:
// port 0 is the CPU MUL instruction path, port 1 the auxiliary/DMA path.
// A round-robin arbiter accepts one request at a time, latches its operands,
// pulses mul_start once, waits for mul_done (guarded by a watchdog) and then
// returns the 16-bit product on the winning port's response channel.
//
// Handshake rule, used identically on every channel in this block:
//   a transfer happens on a rising clk edge where valid and ready are both
//   high. The sender keeps valid and its payload stable until that edge; the
//   receiver may raise or drop ready at any time and ready never depends on
//   anything the sender has not already committed to.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset_n      asynchronous active-low reset
//   req_valid[i] request valid from port i
//   req_ready[i] request accept to port i (IDLE only, at most one bit high)
//   req_a/req_b  operands, port 0 in [7:0], port 1 in [15:8]
//   rsp_valid[i] response valid to port i (at most one bit high)
//   rsp_ready[i] response accept from port i
//   rsp_data     16-bit product, meaningful while a rsp_valid bit is high
//   rsp_err      set with rsp_valid when the operation was aborted by timeout
//   mul_start    one-cycle start pulse to the multiplier
//   mul_a/mul_b  operands to the multiplier, held from ISSUE through WAIT
//   mul_busy     multiplier busy
//   mul_done     multiplier done pulse
//   mul_p_low    product bits [7:0]
//   mul_p_high   product bits [15:8]
//   arb_busy     high in every state except IDLE
//   state_dbg    current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//
// TIMEOUT_CYCLES: number of WAIT cycles without mul_done before the
// operation is aborted; legal range 10..255.
// -----------------------------------------------------------------------------
module mul_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        mul_start,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic        mul_busy,
  input  logic        mul_done,
  input  logic [7:0]  mul_p_low,
  input  logic [7:0]  mul_p_high,
  output logic        arb_busy,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Counter value on the last permitted WAIT cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0] state;
  logic       last_grant;   // port served most recently
  logic       owner;        // port that owns the operation in flight
  logic [7:0] to_cnt;       // WAIT cycles elapsed without mul_done

  logic       grant;
  logic       any_req;
  logic       accept;
  logic       rsp_fire;
  logic       timeout_hit;

  // ---------------------------------------------------------------------------
  // Arbitration: a lone requester wins outright; under contention the port
  // that was not served last wins, which gives strict alternation.
  // ---------------------------------------------------------------------------
  always_comb begin
    any_req = |req_valid;
    grant   = 1'b0;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (state == S_IDLE && any_req) begin
      req_ready = grant ? 2'b10 : 2'b01;
    end
  end

  assign accept = |(req_valid & req_ready);

  // Start is held off while the multiplier reports busy, so exactly one pulse
  // reaches it per accepted request.
  assign mul_start = (state == S_ISSUE) && !mul_busy;

  always_comb begin
    rsp_valid = 2'b00;
    if (state == S_RESP) begin
      rsp_valid = owner ? 2'b10 : 2'b01;
    end
  end

  // Only the owner's ready bit can complete the response.
  assign rsp_fire    = |(rsp_valid & rsp_ready);
  assign timeout_hit = (to_cnt == TO_LAST);
  assign arb_busy    = (state != S_IDLE);
  assign state_dbg   = state;

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      to_cnt     <= 8'd0;
      mul_a      <= 8'd0;
      mul_b      <= 8'd0;
      rsp_data   <= 16'd0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            mul_a      <= grant ? req_a[15:8] : req_a[7:0];
            mul_b      <= grant ? req_b[15:8] : req_b[7:0];
            owner      <= grant;
            last_grant <= grant;
            state      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (!mul_busy) begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          // A done pulse on the final permitted cycle still counts as success.
          if (mul_done) begin
            rsp_data <= {mul_p_high, mul_p_low};
            rsp_err  <= 1'b0;
            to_cnt   <= 8'd0;
            state    <= S_RESP;
          end else if (timeout_hit) begin
            rsp_data <= 16'd0;
            rsp_err  <= 1'b1;
            to_cnt   <= 8'd0;
            state    <= S_RESP;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end

        S_RESP: begin
          // Returning to IDLE first means a new request is never accepted in
          // the same cycle as the response handshake.
          if (rsp_fire) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_req_ready_onehot : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(req_ready));
  a_rsp_valid_onehot : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(rsp_valid));
  a_start_in_issue : assert property (@(posedge clk) disable iff (!reset_n)
    mul_start |-> (state == S_ISSUE));
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_arbiter: directed bench for mul_arbiter with a behavioural 8-step
// multiplier (start seen in cycle N, done pulse in cycle N+9).
// -----------------------------------------------------------------------------
module tb_mul_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_busy;
  logic        mul_done;
  logic [7:0]  mul_p_low;
  logic [7:0]  mul_p_high;
  logic        arb_busy;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected responses for the contention run: {port, product}.
  logic [16:0] exp_q[$];

  mul_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_busy   (mul_busy),
    .mul_done   (mul_done),
    .mul_p_low  (mul_p_low),
    .mul_p_high (mul_p_high),
    .arb_busy   (arb_busy),
    .state_dbg  (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "global timeout");
  end

  // ---------------------------------------------------------------------------
  // Behavioural multiplier, updated on the falling edge so it never races the
  // arbiter's rising-edge sampling.
  // ---------------------------------------------------------------------------
  logic       hang;
  logic       ext_busy;
  logic       running;
  int         mcnt;
  logic [7:0] ma, mb;

  assign mul_busy = ext_busy | (running && mcnt != 9);

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running    = 1'b0;
      mcnt       = 0;
      mul_done   = 1'b0;
      mul_p_low  = 8'd0;
      mul_p_high = 8'd0;
      ma         = 8'd0;
      mb         = 8'd0;
    end else begin
      mul_done = 1'b0;
      if (running) begin
        mcnt = mcnt - 1;
        if (mcnt == 0) begin
          mul_done                = 1'b1;
          running                 = 1'b0;
          {mul_p_high, mul_p_low} = 16'(ma) * 16'(mb);
        end
      end else if (mul_start && !hang) begin
        running = 1'b1;
        mcnt    = 9;
        ma      = mul_a;
        mb      = mul_b;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = 2'b00;
    req_a     = 16'd0;
    req_b     = 16'd0;
    rsp_ready = 2'b00;
    hang      = 1'b0;
    ext_busy  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  // Runs one operation starting in an IDLE cycle (cycle 0). req_a/req_b must
  // already be set. Returns in the IDLE cycle after the response handshake,
  // with req_valid still driven to vld.
  task automatic run_txn(input string tag, input logic [1:0] vld, input int port,
                         input logic [7:0] ea, input logic [7:0] eb,
                         input logic [15:0] edata, input logic eerr,
                         input int elat, input int busy_cyc, input int stall);
    int         cyc;
    int         starts;
    logic [1:0] oh;
    oh        = (port == 1) ? 2'b10 : 2'b01;
    rsp_ready = (stall > 0) ? ~oh : 2'b11;
    req_valid = vld;
    ext_busy  = 1'b0;
    #1;
    check({tag, ":req_ready"}, 32'(req_ready), 32'(oh));
    cyc    = 0;
    starts = 0;
    while (rsp_valid == 2'b00 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      ext_busy = (cyc <= busy_cyc);
      #1;
      if (mul_start) begin
        starts++;
        if (starts == 1) begin
          check({tag, ":start_cycle"}, 32'(cyc), 32'(1 + busy_cyc));
          check({tag, ":mul_ab"}, {16'd0, mul_a, mul_b}, {16'd0, ea, eb});
        end
      end
    end
    ext_busy = 1'b0;
    check({tag, ":latency"}, 32'(cyc), 32'(elat));
    check({tag, ":starts"}, 32'(starts), 32'd1);
    check({tag, ":rsp_valid"}, 32'(rsp_valid), 32'(oh));
    check({tag, ":rsp_data"}, 32'(rsp_data), 32'(edata));
    check({tag, ":rsp_err"}, 32'(rsp_err), 32'(eerr));
    for (int s = 1; s <= stall; s++) begin
      @(posedge clk);
      #2;
      check({tag, ":stall_valid"}, {14'd0, rsp_valid, rsp_data}, {14'd0, oh, edata});
      check({tag, ":stall_state"}, {28'd0, req_ready, state_dbg}, {28'd0, 2'b00, S_RESP});
      if (s == stall) rsp_ready = 2'b11;
    end
    @(posedge clk);
    #2;
    check({tag, ":back_idle"}, {28'd0, state_dbg, rsp_valid}, {28'd0, S_IDLE, 2'b00});
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int         seen;
    logic [16:0] e;

    do_reset();
    check("reset_ctrl", {24'd0, state_dbg, req_ready, rsp_valid, mul_start, arb_busy},
          32'd0);
    check("reset_data", {15'd0, rsp_err, rsp_data}, 32'd0);
    check("reset_ops", {16'd0, mul_a, mul_b}, 32'd0);

    // Port 0 alone: 13 * 11 = 143.
    req_a = {8'd0, 8'd13};
    req_b = {8'd0, 8'd11};
    run_txn("p0_only", 2'b01, 0, 8'd13, 8'd11, 16'h008F, 1'b0, 11, 0, 0);
    req_valid = 2'b00;

    // Contention from reset: port 0 first, then strict alternation.
    do_reset();
    req_a = {8'd16, 8'd255};
    req_b = {8'd16, 8'd255};
    exp_q.push_back({1'b0, 16'hFE01});
    exp_q.push_back({1'b1, 16'h0100});
    exp_q.push_back({1'b0, 16'hFE01});
    exp_q.push_back({1'b1, 16'h0100});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[16])
        run_txn("rr", 2'b11, 1, 8'd16, 8'd16, e[15:0], 1'b0, 11, 0, 0);
      else
        run_txn("rr", 2'b11, 0, 8'd255, 8'd255, e[15:0], 1'b0, 11, 0, 0);
    end
    req_valid = 2'b00;

    // Backpressure on port 1: 7 * 6 = 42, response held for 5 cycles; port 0
    // ready is high meanwhile and must not complete the response.
    req_a = {8'd7, 8'd0};
    req_b = {8'd6, 8'd0};
    run_txn("bp", 2'b10, 1, 8'd7, 8'd6, 16'h002A, 1'b0, 11, 0, 5);
    req_valid = 2'b00;

    // Hung multiplier: 16 WAIT cycles (2..17), error response in cycle 18.
    hang  = 1'b1;
    req_a = {8'd0, 8'd1};
    req_b = {8'd0, 8'd1};
    run_txn("hang", 2'b01, 0, 8'd1, 8'd1, 16'h0000, 1'b1, 18, 0, 0);
    req_valid = 2'b00;
    hang      = 1'b0;

    // Next request after the abort is served normally: 3 * 5 = 15.
    req_a = {8'd3, 8'd0};
    req_b = {8'd5, 8'd0};
    run_txn("after_hang", 2'b10, 1, 8'd3, 8'd5, 16'h000F, 1'b0, 11, 0, 0);
    req_valid = 2'b00;

    // Multiplier busy for ISSUE cycles 1..3: start in cycle 4, 9 * 9 = 81.
    req_a = {8'd0, 8'd9};
    req_b = {8'd0, 8'd9};
    run_txn("busy", 2'b01, 0, 8'd9, 8'd9, 16'h0051, 1'b0, 14, 3, 0);
    req_valid = 2'b00;

    // Reset while in WAIT: everything clears at once, no late response.
    req_a     = {8'd0, 8'd5};
    req_b     = {8'd0, 8'd5};
    rsp_ready = 2'b11;
    req_valid = 2'b01;
    repeat (4) @(posedge clk);
    #2;
    req_valid = 2'b00;
    check("mid_wait_state", 32'(state_dbg), 32'(S_WAIT));
    reset_n = 1'b0;
    #1;
    check("mid_reset_ctrl", {24'd0, state_dbg, req_ready, rsp_valid, mul_start, arb_busy},
          32'd0);
    check("mid_reset_data", {15'd0, rsp_err, rsp_data}, 32'd0);
    check("mid_reset_ops", {16'd0, mul_a, mul_b}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    seen    = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #2;
      if (rsp_valid != 2'b00) seen++;
    end
    check("no_late_rsp", 32'(seen), 32'd0);

    // After release port 0 wins first even with both requesting: 2 * 3 = 6.
    req_a = {8'd4, 8'd2};
    req_b = {8'd4, 8'd3};
    run_txn("post_reset", 2'b11, 0, 8'd2, 8'd3, 16'h0006, 1'b0, 11, 0, 0);
    req_valid = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
